mpeg_bit_window: RTL and testbench

Parametrised MPEG bitstream window for the decoder front end. Accepts bytes over a valid/ready stream into an internal byte FIFO and keeps an MSB-aligned lookahead window of `WIN_BITS` bits. Lets the parser consume 0..`WIN_BITS` bits per cycle under a handshake. Refills in the same cycle as a flush, tracks absolute bit position, and handles end-of-stream.

---
 rtl/mpeg_bs_pkg.sv | 31 +++
 rtl/mpeg_byte_fifo.sv | 63 ++++++
 rtl/mpeg_bit_window.sv | 187 ++++++++++++++++++
 tb/tb_mpeg_bit_window.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_bs_pkg.sv
// Shared constants and helpers for the MPEG bitstream window front end.
// Includes the sequence_end_code byte source used when the build defines
// MPEG_BIT_WINDOW_EOS_PAD_EN.
package mpeg_bs_pkg;

    // sequence_end_code, emitted MSB byte first as stream padding
    localparam logic [31:0] SEQ_END_CODE = 32'h000001B7;

    // Default lookahead window width in bits
    localparam int WIN_BITS_DEF = 32;

    // Width needed to hold a count in the range 0..v inclusive
    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction

    // Byte idx (0 = most significant) of the sequence_end_code
    function automatic logic [7:0] pad_byte(input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0: b = SEQ_END_CODE[31:24];
            2'd1: b = SEQ_END_CODE[23:16];
            2'd2: b = SEQ_END_CODE[15:8];
            2'd3: b = SEQ_END_CODE[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mpeg_byte_fifo.sv
// Byte FIFO feeding the bit window. DEPTH entries of 8 bits, no
// fall-through: a byte pushed at an edge is at the head after that edge.
// Simultaneous push and pop are allowed at any fill level; a pop on an
// empty FIFO is ignored and a push on a full FIFO is only taken together
// with a pop.
module mpeg_byte_fifo
    import mpeg_bs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write; contents need no reset since the level gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and level bookkeeping; pointers wrap since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

endmodule

// File: rtl/mpeg_bit_window.sv
// MPEG bitstream window: bytes stream into a FIFO and are packed into an
// MSB-aligned lookahead window that the parser consumes 0..WIN_BITS bits
// at a time. Flush and one-byte refill happen in the same cycle.
// Optional feature macro: MPEG_BIT_WINDOW_EOS_PAD_EN (pads the window with
// 00 00 01 B7 after the final byte, and counts only real bits for eos).
module mpeg_bit_window
    import mpeg_bs_pkg::*;
#(
    parameter int WIN_BITS = WIN_BITS_DEF,
    parameter int DEPTH    = 8,
    parameter int NW       = cnt_w(WIN_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                flush_valid,
    input  logic [NW-1:0]       flush_n,
    output logic                flush_ready,
    output logic [WIN_BITS-1:0] win,
    output logic                win_valid,
    output logic [31:0]         bit_pos,
    output logic                eos,
    output logic                err
);

    localparam int LW = cnt_w(DEPTH);
    localparam logic [NW-1:0] REFILL_MAX = NW'(WIN_BITS - 8);

    // Bits actually removed: the request clamped to what is available
    function automatic logic [NW-1:0] take_bits(input logic [NW-1:0] req,
                                                input logic [NW-1:0] avail);
        return (req > avail) ? avail : req;
    endfunction

    logic [WIN_BITS-1:0] r_win;
    logic [NW-1:0]       r_incnt;
    logic [31:0]         r_bit_pos;
    logic                r_last_in;
    logic                r_last_ins;
    logic                r_eos;
    logic                r_err;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [7:0]          w_fifo_data;
    logic [LW-1:0]       w_fifo_level;

    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_over;
    logic [NW-1:0]       w_n;
    logic [NW-1:0]       w_k;
    logic                w_room;
    logic                w_refill;
    logic [7:0]          w_ref_byte;
    logic [NW-1:0]       w_off;
    logic [WIN_BITS-1:0] w_win_sh;
    logic [WIN_BITS-1:0] w_ins;
    logic [WIN_BITS-1:0] w_win_nxt;
    logic [NW-1:0]       w_incnt_nxt;
    logic                w_last_ins_nxt;
    logic                w_eos_nxt;

    mpeg_byte_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (in_byte),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // Handshakes depend on registered state only
    assign in_ready    = !w_fifo_full && !r_last_in;
    assign w_push      = in_valid && in_ready;
`ifdef MPEG_BIT_WINDOW_EOS_PAD_EN
    assign win_valid   = (r_incnt > REFILL_MAX);
`else
    assign win_valid   = (r_incnt > REFILL_MAX) || (r_last_ins && (r_incnt != '0));
`endif
    assign flush_ready = win_valid;

    // Flush: shift out n bits, vacated low bits fill with zeros
    assign w_flush  = flush_valid && flush_ready;
    assign w_over   = w_flush && (flush_n > r_incnt);
    assign w_n      = w_flush ? take_bits(flush_n, r_incnt) : '0;
    assign w_k      = r_incnt - w_n;
    assign w_win_sh = r_win << w_n;

    // Refill: at most one byte, placed directly below the remaining bits
    assign w_room   = (w_k <= REFILL_MAX);
    assign w_pop    = w_room && !w_fifo_empty;
    assign w_off    = REFILL_MAX - w_k;

`ifdef MPEG_BIT_WINDOW_EOS_PAD_EN
    logic [1:0]    r_pad_idx;
    logic [NW-1:0] r_real;
    logic          w_pad_sel;
    logic [NW-1:0] w_real_k;
    logic [NW-1:0] w_real_nxt;

    // Once the last real byte has left the FIFO, pad bytes take its place
    assign w_pad_sel  = w_fifo_empty && r_last_in;
    assign w_refill   = w_room && (!w_fifo_empty || w_pad_sel);
    assign w_ref_byte = w_pad_sel ? pad_byte(r_pad_idx) : w_fifo_data;
    // Real bits always sit above pad bits, so they leave the window first
    assign w_real_k   = r_real - take_bits(w_n, r_real);
    assign w_real_nxt = w_pop ? (w_real_k + NW'(8)) : w_real_k;
`else
    assign w_refill   = w_pop;
    assign w_ref_byte = w_fifo_data;
`endif

    assign w_ins       = {{(WIN_BITS-8){1'b0}}, w_ref_byte} << w_off;
    assign w_win_nxt   = w_refill ? (w_win_sh | w_ins) : w_win_sh;
    assign w_incnt_nxt = w_refill ? (w_k + NW'(8)) : w_k;

    // The final byte is the one popped while it is alone in the FIFO after in_last
    assign w_last_ins_nxt = r_last_ins ||
                            (r_last_in && w_pop && (w_fifo_level == LW'(1)));

`ifdef MPEG_BIT_WINDOW_EOS_PAD_EN
    assign w_eos_nxt = w_last_ins_nxt && (w_real_nxt == '0);
`else
    logic [LW-1:0] w_lvl_nxt;
    assign w_lvl_nxt = w_fifo_level + LW'(w_push) - LW'(w_pop);
    assign w_eos_nxt = w_last_ins_nxt && (w_incnt_nxt == '0) && (w_lvl_nxt == '0);
`endif

    // Window, bit counters and stream status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win      <= '0;
            r_incnt    <= '0;
            r_bit_pos  <= '0;
            r_last_in  <= 1'b0;
            r_last_ins <= 1'b0;
            r_eos      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_win      <= w_win_nxt;
            r_incnt    <= w_incnt_nxt;
            r_bit_pos  <= r_bit_pos + 32'(w_n);
            r_last_ins <= w_last_ins_nxt;
            if (w_push && in_last) begin
                r_last_in <= 1'b1;
            end
            if (w_over) begin
                r_err <= 1'b1;
            end
            if (w_eos_nxt) begin
                r_eos <= 1'b1;
            end
        end
    end

`ifdef MPEG_BIT_WINDOW_EOS_PAD_EN
    // Pad sequence position and count of real bits left in the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pad_idx <= '0;
            r_real    <= '0;
        end else begin
            r_real <= w_real_nxt;
            if (w_refill && w_pad_sel) begin
                r_pad_idx <= r_pad_idx + 2'd1;
            end
        end
    end
`endif

    assign win     = r_win;
    assign bit_pos = r_bit_pos;
    assign eos     = r_eos;
    assign err     = r_err;

endmodule

// File: tb/tb_mpeg_bit_window.sv
// Directed bench for mpeg_bit_window (WIN_BITS=32, DEPTH=8).
// Follows MPEG_BIT_WINDOW_EOS_PAD_EN for the end-of-stream expectations.
module tb_mpeg_bit_window;

    localparam int WB = 32;
    localparam int DP = 8;
    localparam int NWB = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [7:0]     in_byte = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic           flush_valid = 1'b0;
    logic [NWB-1:0] flush_n = '0;
    logic           flush_ready;
    logic [WB-1:0]  win;
    logic           win_valid;
    logic [31:0]    bit_pos;
    logic           eos;
    logic           err;

    int n_chk = 0;
    int n_fail = 0;

    mpeg_bit_window #(
        .WIN_BITS (WB),
        .DEPTH    (DP),
        .NW       (NWB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .flush_valid (flush_valid),
        .flush_n     (flush_n),
        .flush_ready (flush_ready),
        .win         (win),
        .win_valid   (win_valid),
        .bit_pos     (bit_pos),
        .eos         (eos),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           iv;
        logic [7:0]     ib;
        logic           fv;
        logic [NWB-1:0] fn;
        logic [31:0]    e_win;
        logic           e_wv;
        logic [31:0]    e_bp;
        logic           e_ir;
        logic           e_err;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] ib, input logic il,
                         input logic fv, input logic [NWB-1:0] fn);
        in_valid    = iv;
        in_byte     = ib;
        in_last     = il;
        flush_valid = fv;
        flush_n     = fn;
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 0, '0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_wv"}, win_valid, 0);
        chk({tag, "_fr"}, flush_ready, 0);
        chk({tag, "_eos"}, eos, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ir"}, in_ready, 1);
        chk({tag, "_bp"}, bit_pos, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        logic rdy;

        //              iv  ib     fv fn  win           wv bp  ir err
        vt[0]  = '{1'b1, 8'h12, 1'b0, 6'd0,  32'h00000000, 1'b0, 32'd0,  1'b1, 1'b0};
        vt[1]  = '{1'b1, 8'h34, 1'b0, 6'd0,  32'h12000000, 1'b0, 32'd0,  1'b1, 1'b0};
        vt[2]  = '{1'b1, 8'h56, 1'b0, 6'd0,  32'h12340000, 1'b0, 32'd0,  1'b1, 1'b0};
        vt[3]  = '{1'b1, 8'h78, 1'b0, 6'd0,  32'h12345600, 1'b0, 32'd0,  1'b1, 1'b0};
        vt[4]  = '{1'b1, 8'h9A, 1'b0, 6'd0,  32'h12345678, 1'b1, 32'd0,  1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 6'd0,  32'h12345678, 1'b1, 32'd0,  1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 6'd5,  32'h468ACF00, 1'b1, 32'd5,  1'b1, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 6'd4,  32'h68ACF134, 1'b1, 32'd9,  1'b1, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 6'd0,  32'h68ACF134, 1'b1, 32'd9,  1'b1, 1'b0};
        vt[9]  = '{1'b1, 8'hC5, 1'b0, 6'd0,  32'h68ACF134, 1'b1, 32'd9,  1'b1, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 6'd7,  32'h56789AC5, 1'b1, 32'd16, 1'b1, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b1, 6'd33, 32'h00000000, 1'b0, 32'd48, 1'b1, 1'b1};
        vt[12] = '{1'b0, 8'h00, 1'b0, 6'd0,  32'h00000000, 1'b0, 32'd48, 1'b1, 1'b1};
        vt[13] = '{1'b0, 8'h00, 1'b1, 6'd8,  32'h00000000, 1'b0, 32'd48, 1'b1, 1'b1};

        // Reset values
        drive(0, 8'h00, 0, 0, '0);
        #2;
        chk_reset_state("rst0");
        do_reset();

        // Happy path, zero flush, refill, over-flush, flush while not valid
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].iv, vt[i].ib, 1'b0, vt[i].fv, vt[i].fn);
            tick();
            chk($sformatf("vec%0d_win", i), win, vt[i].e_win);
            chk($sformatf("vec%0d_wv", i), win_valid, vt[i].e_wv);
            chk($sformatf("vec%0d_fr", i), flush_ready, vt[i].e_wv);
            chk($sformatf("vec%0d_bp", i), bit_pos, vt[i].e_bp);
            chk($sformatf("vec%0d_ir", i), in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
        end

        // Backpressure: 4 bytes in the window plus 8 in the FIFO
        do_reset();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, 8'(acc + 1), 0, 0, '0);
            rdy = in_ready;
            tick();
            if (rdy) acc++;
        end
        chk("bp_accepted", acc, 12);
        chk("bp_ir_low", in_ready, 0);
        chk("bp_win", win, 32'h01020304);
        drive(0, 8'h00, 0, 1, 6'd8);
        tick();
        chk("bp_flush_win", win, 32'h02030405);
        chk("bp_flush_bp", bit_pos, 8);
        acc2 = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 8'(13 + acc2), 0, 0, '0);
            rdy = in_ready;
            tick();
            if (rdy) acc2++;
        end
        chk("bp_extra_accepted", acc2, 1);
        chk("bp_ir_low2", in_ready, 0);

        // Asynchronous reset between edges with a full FIFO
        drive(0, 8'h00, 0, 0, '0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("arst");
        tick();
        rst = 1'b1;
        drive(1, 8'hE1, 0, 0, '0);
        tick();
        drive(0, 8'h00, 0, 0, '0);
        tick();
        chk("arst_first_byte", win[31:24], 8'hE1);
        chk("arst_rest_zero", win[23:0], 24'h0);

        // End of stream with a single byte
        do_reset();
        drive(1, 8'hAB, 1, 0, '0);
        tick();
        drive(0, 8'h00, 0, 0, '0);
        chk("eos_ir_after_last", in_ready, 0);
`ifdef MPEG_BIT_WINDOW_EOS_PAD_EN
        tick();
        tick();
        tick();
        chk("pad_wv_24bits", win_valid, 0);
        tick();
        chk("pad_win", win, 32'hAB000001);
        chk("pad_wv", win_valid, 1);
        chk("pad_eos_pre", eos, 0);
        drive(0, 8'h00, 0, 1, 6'd8);
        tick();
        drive(0, 8'h00, 0, 0, '0);
        chk("pad_eos", eos, 1);
        chk("pad_win_after", win, 32'h000001B7);
        chk("pad_bp", bit_pos, 8);
        tick();
        tick();
        chk("pad_eos_hold", eos, 1);
        chk("pad_ir_hold", in_ready, 0);
`else
        tick();
        chk("eos_win", win, 32'hAB000000);
        chk("eos_wv", win_valid, 1);
        chk("eos_pre", eos, 0);
        drive(0, 8'h00, 0, 1, 6'd8);
        tick();
        drive(0, 8'h00, 0, 0, '0);
        chk("eos_set", eos, 1);
        chk("eos_wv_low", win_valid, 0);
        chk("eos_bp", bit_pos, 8);
        chk("eos_err", err, 0);
        tick();
        tick();
        tick();
        chk("eos_hold", eos, 1);
        chk("eos_ir_hold", in_ready, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
